// File: rtl/fc_seq_pkg.sv
// Shared types and default widths for the FC layer sequencer.
package fc_seq_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      ISSUE,
      WAIT,
      DONE
   } state_t;

   localparam int NUM_NEURONS_DEF = 16;
   localparam int IN_W_DEF        = 128;
   localparam int WT_W_DEF        = 32;
   localparam int SUM_W_DEF       = 9;
   localparam int TIMEOUT_CYC_DEF = 8;

endpackage

// File: rtl/fc_layer_sequencer_if.sv
// Neuron and weight-ROM side bus of the FC layer sequencer.
interface fc_layer_sequencer_if #(
   parameter int NUM_NEURONS = 16,
   parameter int IN_W        = 128,
   parameter int WT_W        = 32,
   parameter int SUM_W       = 9
);
   localparam int IDX_W = $clog2(NUM_NEURONS);

   logic [IDX_W-1:0] wmem_addr;
   logic             wmem_rd;
   logic [WT_W:0]    wmem_rdata;
   logic             n_start;
   logic [WT_W-1:0]  n_weight;
   logic             n_bias;
   logic [IN_W-1:0]  n_in;
   logic [SUM_W-1:0] n_out;
   logic             n_end;

   modport master (
      output wmem_addr, wmem_rd, n_start, n_weight, n_bias, n_in,
      input  wmem_rdata, n_out, n_end
   );

   modport slave (
      input  wmem_addr, wmem_rd, n_start, n_weight, n_bias, n_in,
      output wmem_rdata, n_out, n_end
   );
endinterface

// File: rtl/fc_seq_timer.sv
// WAIT-state cycle counter; expired is high during the LIMIT-th enabled cycle.
module fc_seq_timer
   import fc_seq_pkg::*;
#(
   parameter int LIMIT = TIMEOUT_CYC_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);
   localparam int CNT_W = $clog2(LIMIT + 1);

   logic [CNT_W-1:0] count_reg;

   always_ff @(posedge clk) begin
      if (!reset) begin
         count_reg <= '0;
      end else if (clear) begin
         count_reg <= '0;
      end else if (enable && !expired) begin
         count_reg <= count_reg + CNT_W'(1);
      end
   end

   assign expired = (count_reg == CNT_W'(LIMIT - 1));
endmodule

// File: rtl/fc_layer_sequencer.sv
// Runs one binarized FC neuron over every output neuron of a layer.
// Build option: FC_SEQ_SIGN_ACT_EN adds the packed sign-activation vector res_bits.
module fc_layer_sequencer
   import fc_seq_pkg::*;
#(
   parameter int  NUM_NEURONS = NUM_NEURONS_DEF,
   parameter int  IN_W        = IN_W_DEF,
   parameter int  WT_W        = WT_W_DEF,
   parameter int  SUM_W       = SUM_W_DEF,
   parameter int  TIMEOUT_CYC = TIMEOUT_CYC_DEF,
   localparam int IDX_W       = $clog2(NUM_NEURONS)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic [IN_W-1:0]        in_vec,
   output logic                   busy,
   output logic                   done,
   output logic                   err,
   output logic                   res_valid,
   output logic [IDX_W-1:0]       res_idx,
   output logic [SUM_W-1:0]       res_data,
   output logic [NUM_NEURONS-1:0] res_bits,
   fc_layer_sequencer_if.master   bus
);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

   state_t           state_reg;
   logic [IDX_W-1:0] idx_reg;
   logic [IDX_W-1:0] wmem_addr_reg;
   logic             wmem_rd_reg;
   logic             n_start_reg;
   logic [WT_W-1:0]  n_weight_reg;
   logic             n_bias_reg;
   logic [IN_W-1:0]  n_in_reg;
   logic             busy_reg;
   logic             done_reg;
   logic             err_reg;
   logic             res_valid_reg;
   logic [IDX_W-1:0] res_idx_reg;
   logic [SUM_W-1:0] res_data_reg;
   logic             timer_expired;

   fc_seq_timer #(.LIMIT(TIMEOUT_CYC)) u_timer (
      .clk     (clk),
      .reset   (reset),
      .clear   (state_reg == ISSUE),
      .enable  (state_reg == WAIT),
      .expired (timer_expired)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_reg     <= IDLE;
         idx_reg       <= '0;
         wmem_addr_reg <= '0;
         wmem_rd_reg   <= 1'b0;
         n_start_reg   <= 1'b0;
         n_weight_reg  <= '0;
         n_bias_reg    <= 1'b0;
         n_in_reg      <= '0;
         busy_reg      <= 1'b0;
         done_reg      <= 1'b0;
         err_reg       <= 1'b0;
         res_valid_reg <= 1'b0;
         res_idx_reg   <= '0;
         res_data_reg  <= '0;
      end else begin
         wmem_rd_reg   <= 1'b0;
         n_start_reg   <= 1'b0;
         done_reg      <= 1'b0;
         res_valid_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (start) begin
                  n_in_reg      <= in_vec;
                  idx_reg       <= '0;
                  err_reg       <= 1'b0;
                  busy_reg      <= 1'b1;
                  wmem_rd_reg   <= 1'b1;
                  wmem_addr_reg <= '0;
                  state_reg     <= FETCH;
               end
            end
            FETCH: begin
               n_start_reg <= 1'b1;
               state_reg   <= ISSUE;
            end
            ISSUE: begin
               // ROM data for the fetched row is valid during this cycle.
               n_weight_reg <= bus.wmem_rdata[WT_W:1];
               n_bias_reg   <= bus.wmem_rdata[0];
               state_reg    <= WAIT;
            end
            WAIT: begin
               if (bus.n_end) begin
                  res_valid_reg <= 1'b1;
                  res_idx_reg   <= idx_reg;
                  res_data_reg  <= bus.n_out;
                  if (idx_reg == LAST_IDX) begin
                     done_reg  <= 1'b1;
                     state_reg <= DONE;
                  end else begin
                     idx_reg       <= idx_reg + IDX_W'(1);
                     wmem_rd_reg   <= 1'b1;
                     wmem_addr_reg <= idx_reg + IDX_W'(1);
                     state_reg     <= FETCH;
                  end
               end else if (timer_expired) begin
                  err_reg   <= 1'b1;
                  done_reg  <= 1'b1;
                  state_reg <= DONE;
               end
            end
            DONE: begin
               busy_reg  <= 1'b0;
               state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

`ifdef FC_SEQ_SIGN_ACT_EN
   logic [NUM_NEURONS-1:0] res_bits_reg;

   // One flop per neuron: set to the sign activation when that neuron's sum is captured.
   for (genvar gi = 0; gi < NUM_NEURONS; gi++) begin : g_sign
      always_ff @(posedge clk) begin
         if (!reset) begin
            res_bits_reg[gi] <= 1'b0;
         end else if (state_reg == IDLE && start) begin
            res_bits_reg[gi] <= 1'b0;
         end else if (state_reg == WAIT && bus.n_end && idx_reg == IDX_W'(gi)) begin
            res_bits_reg[gi] <= ~bus.n_out[SUM_W-1];
         end
      end
   end
   assign res_bits = res_bits_reg;
`else
   assign res_bits = '0;
`endif

   assign bus.wmem_addr = wmem_addr_reg;
   assign bus.wmem_rd   = wmem_rd_reg;
   assign bus.n_start   = n_start_reg;
   assign bus.n_weight  = n_weight_reg;
   assign bus.n_bias    = n_bias_reg;
   assign bus.n_in      = n_in_reg;
   assign busy          = busy_reg;
   assign done          = done_reg;
   assign err           = err_reg;
   assign res_valid     = res_valid_reg;
   assign res_idx       = res_idx_reg;
   assign res_data      = res_data_reg;
endmodule

// File: tb/tb_fc_layer_sequencer.sv
// Directed and randomized bench for fc_layer_sequencer with a ROM and 3-cycle neuron model.
module tb_fc_layer_sequencer;
   import fc_seq_pkg::*;

   localparam int NN    = 16;
   localparam int IN_W  = 128;
   localparam int WT_W  = 32;
   localparam int SUM_W = 9;
   localparam int TO    = 8;
   localparam int IDX_W = 4;
`ifdef FC_SEQ_SIGN_ACT_EN
   localparam bit SIGN_EN = 1'b1;
`else
   localparam bit SIGN_EN = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic             start = 1'b0;
   logic [IN_W-1:0]  in_vec = '0;
   logic             busy, done, err, res_valid;
   logic [IDX_W-1:0] res_idx;
   logic [SUM_W-1:0] res_data;
   logic [NN-1:0]    res_bits;

   fc_layer_sequencer_if #(.NUM_NEURONS(NN), .IN_W(IN_W), .WT_W(WT_W), .SUM_W(SUM_W)) nbus ();

   fc_layer_sequencer #(
      .NUM_NEURONS(NN), .IN_W(IN_W), .WT_W(WT_W), .SUM_W(SUM_W), .TIMEOUT_CYC(TO)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .in_vec(in_vec),
      .busy(busy), .done(done), .err(err), .res_valid(res_valid),
      .res_idx(res_idx), .res_data(res_data), .res_bits(res_bits), .bus(nbus)
   );

   always #5 clk = ~clk;

   int               cyc = 0;
   int               cd = 0;
   int               issue_cnt = 0;
   int               withhold = -1;
   logic             rd_prev = 1'b0;
   logic [IDX_W-1:0] addr_prev = '0;
   logic [32:0]      rom [NN];
   logic [IN_W-1:0]  layer_in = '0;
   logic [IN_W-1:0]  exp_nin = '0;
   int               res_cyc_q[$];
   logic [IDX_W-1:0] res_idx_q[$];
   logic [SUM_W-1:0] res_data_q[$];
   int               done_cnt = 0;
   int               done_cyc = 0;
   logic             err_at_done = 1'b0;
   logic [NN-1:0]    bits_at_done = '0;
   bit               nin_bad = 1'b0;
   int               s_cyc = 0;
   bit               layer_to = 1'b0;
   logic             err_post = 1'b0;
   logic             busy_post = 1'b0;
   int               n_checks = 0;
   int               n_pass = 0;

   function automatic logic [SUM_W-1:0] calc(input logic [IN_W-1:0] v, input logic [WT_W-1:0] w,
                                             input logic b);
      int s;
      logic signed [3:0] t;
      s = b ? 1 : -1;
      for (int i = 0; i < 32; i++) begin
         t = v[4*i +: 4];
         s = w[i] ? s + int'(t) : s - int'(t);
      end
      return SUM_W'(s);
   endfunction

   function automatic logic [NN-1:0] ref_bits();
      logic [NN-1:0] b;
      logic [SUM_W-1:0] s;
      b = '0;
      for (int i = 0; i < NN; i++) begin
         s = calc(layer_in, rom[i][32:1], rom[i][0]);
         b[i] = ~s[SUM_W-1];
      end
      return SIGN_EN ? b : '0;
   endfunction

   // ROM, neuron and result monitor share one process so their ordering is fixed.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (rd_prev) nbus.wmem_rdata = rom[addr_prev];
         rd_prev   = nbus.wmem_rd;
         addr_prev = nbus.wmem_addr;
         nbus.n_end = 1'b0;
         if (!reset) begin
            cd = 0;
         end else begin
            if (cd > 0) begin
               cd--;
               if (cd == 0) begin
                  nbus.n_out = calc(nbus.n_in, nbus.n_weight, nbus.n_bias);
                  nbus.n_end = 1'b1;
               end
            end
            if (nbus.n_start) begin
               if (issue_cnt != withhold) cd = 3;
               issue_cnt++;
            end
         end
         if (res_valid) begin
            res_cyc_q.push_back(cyc);
            res_idx_q.push_back(res_idx);
            res_data_q.push_back(res_data);
         end
         if (done) begin
            done_cnt++;
            done_cyc     = cyc;
            err_at_done  = err;
            bits_at_done = res_bits;
         end
         if (busy && nbus.n_in !== exp_nin) nin_bad = 1'b1;
      end
   end

   task automatic clear_mon();
      res_cyc_q.delete();
      res_idx_q.delete();
      res_data_q.delete();
      done_cnt  = 0;
      nin_bad   = 1'b0;
      issue_cnt = 0;
   endtask

   task automatic run_layer(input bit hold);
      clear_mon();
      exp_nin = layer_in;
      @(posedge clk);
      #2;
      in_vec = layer_in;
      start  = 1'b1;
      s_cyc  = cyc;
      @(posedge clk);
      #2;
      if (!hold) start = 1'b0;
      in_vec = ~layer_in;
      #1;
      err_post  = err;
      busy_post = busy;
      layer_to  = 1'b1;
      for (int k = 0; k < 300; k++) begin
         if (done_cnt > 0) begin
            layer_to = 1'b0;
            break;
         end
         @(posedge clk);
         #3;
      end
   endtask

   task automatic fill_rom(input logic [32:0] val);
      for (int i = 0; i < NN; i++) rom[i] = val;
   endtask

   task automatic test_reset();
      nbus.wmem_rdata = '0;
      nbus.n_out      = '0;
      nbus.n_end      = 1'b0;
      reset = 1'b0;
      start = 1'b1;
      repeat (3) @(posedge clk);
      #3;
      n_checks++;
      if ({busy, done, err, res_valid} !== 4'b0000) $display("FAIL reset_status: got %b expected 0000", {busy, done, err, res_valid});
      else n_pass++;
      n_checks++;
      if ({res_idx, res_data, res_bits} !== '0) $display("FAIL reset_result: got idx %0d data %0h bits %0h expected all 0", res_idx, res_data, res_bits);
      else n_pass++;
      n_checks++;
      if ({nbus.wmem_rd, nbus.wmem_addr, nbus.n_start, nbus.n_bias} !== '0 || nbus.n_weight !== '0) $display("FAIL reset_bus: got rd %b addr %0d st %b w %0h expected all 0", nbus.wmem_rd, nbus.wmem_addr, nbus.n_start, nbus.n_weight);
      else n_pass++;
      n_checks++;
      if (nbus.n_in !== '0) $display("FAIL reset_n_in: got %0h expected 0", nbus.n_in);
      else n_pass++;
      start = 1'b0;
      @(posedge clk);
      #2;
      reset = 1'b1;
      $display("reset: outputs checked while reset=0");
   endtask

   task automatic test_basic();
      layer_in = {32{4'h1}};
      fill_rom({32'hFFFF_FFFF, 1'b1});
      run_layer(1'b0);
      n_checks++;
      if (layer_to) $display("FAIL basic_timeout: got no done expected done within bound");
      else n_pass++;
      n_checks++;
      if (busy_post !== 1'b1) $display("FAIL basic_busy_rise: got %b expected 1", busy_post);
      else n_pass++;
      n_checks++;
      if (res_idx_q.size() != NN) $display("FAIL basic_count: got %0d expected %0d", res_idx_q.size(), NN);
      else n_pass++;
      for (int i = 0; i < res_idx_q.size(); i++) begin
         n_checks++;
         if (res_idx_q[i] !== IDX_W'(i) || res_data_q[i] !== 9'd33) $display("FAIL basic_result: got idx %0d data %0h expected idx %0d data 021", res_idx_q[i], res_data_q[i], i);
         else n_pass++;
         n_checks++;
         if (res_cyc_q[i] != s_cyc + 6 + 5 * i) $display("FAIL basic_timing: got cycle %0d expected %0d", res_cyc_q[i] - s_cyc, 6 + 5 * i);
         else n_pass++;
      end
      n_checks++;
      if (done_cnt != 1 || done_cyc != s_cyc + 81) $display("FAIL basic_done: got %0d pulses at %0d expected 1 at 81", done_cnt, done_cyc - s_cyc);
      else n_pass++;
      n_checks++;
      if (err_at_done !== 1'b0 || bits_at_done !== ref_bits()) $display("FAIL basic_flags: got err %b bits %0h expected err 0 bits %0h", err_at_done, bits_at_done, ref_bits());
      else n_pass++;
      @(posedge clk);
      #3;
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0) $display("FAIL basic_idle: got busy %b done %b expected 0 0", busy, done);
      else n_pass++;
      $display("basic: %0d results, done at +%0d", res_idx_q.size(), done_cyc - s_cyc);
   endtask

   task automatic test_negative_row();
      layer_in = {32{4'h1}};
      fill_rom({32'hFFFF_FFFF, 1'b1});
      rom[3] = 33'd0;
      run_layer(1'b0);
      n_checks++;
      if (layer_to || res_idx_q.size() != NN) $display("FAIL neg_count: got %0d results expected %0d", res_idx_q.size(), NN);
      else begin
         n_pass++;
         n_checks++;
         if (res_idx_q[3] !== 4'd3 || res_data_q[3] !== 9'h1DF) $display("FAIL neg_row3: got idx %0d data %0h expected idx 3 data 1df", res_idx_q[3], res_data_q[3]);
         else n_pass++;
         n_checks++;
         if (res_data_q[4] !== 9'd33) $display("FAIL neg_row4: got %0h expected 021", res_data_q[4]);
         else n_pass++;
      end
      n_checks++;
      if (bits_at_done !== (SIGN_EN ? 16'hFFF7 : 16'h0000)) $display("FAIL neg_bits: got %0h expected %0h", bits_at_done, SIGN_EN ? 16'hFFF7 : 16'h0000);
      else n_pass++;
      $display("negative_row: row3 data %0h bits %0h", res_data_q.size() > 3 ? res_data_q[3] : 9'h0, bits_at_done);
   endtask

   task automatic test_start_held();
      int n_res;
      layer_in = {32{4'h2}};
      fill_rom({32'h0F0F_0F0F, 1'b0});
      run_layer(1'b1);
      n_checks++;
      if (layer_to || done_cnt != 1 || done_cyc != s_cyc + 81) $display("FAIL held_done: got %0d pulses at %0d expected 1 at 81", done_cnt, done_cyc - s_cyc);
      else n_pass++;
      n_checks++;
      if (res_idx_q.size() != NN) $display("FAIL held_count: got %0d expected %0d", res_idx_q.size(), NN);
      else n_pass++;
      @(posedge clk);
      #2;
      start = 1'b0;
      #1;
      n_checks++;
      if (busy !== 1'b0) $display("FAIL held_idle_busy: got %b expected 0", busy);
      else n_pass++;
      n_res = res_idx_q.size();
      repeat (10) @(posedge clk);
      #3;
      n_checks++;
      if (busy !== 1'b0 || res_idx_q.size() != n_res || done_cnt != 1) $display("FAIL held_no_restart: got busy %b results %0d dones %0d expected 0 %0d 1", busy, res_idx_q.size(), done_cnt, n_res);
      else n_pass++;
      $display("start_held: %0d results, %0d done pulse", n_res, done_cnt);
   endtask

   task automatic test_timeout();
      layer_in = {32{4'h3}};
      fill_rom({32'hAAAA_5555, 1'b1});
      withhold = 5;
      run_layer(1'b0);
      withhold = -1;
      n_checks++;
      if (layer_to || done_cnt != 1 || done_cyc != s_cyc + 36) $display("FAIL to_done: got %0d pulses at %0d expected 1 at 36", done_cnt, done_cyc - s_cyc);
      else n_pass++;
      n_checks++;
      if (err_at_done !== 1'b1) $display("FAIL to_err: got %b expected 1", err_at_done);
      else n_pass++;
      n_checks++;
      if (res_idx_q.size() != 5 || res_idx_q[res_idx_q.size()-1] !== 4'd4) $display("FAIL to_results: got %0d results expected 5 ending at idx 4", res_idx_q.size());
      else n_pass++;
      repeat (3) @(posedge clk);
      #3;
      n_checks++;
      if (err !== 1'b1) $display("FAIL to_sticky: got %b expected 1", err);
      else n_pass++;
      $display("timeout: %0d results, err %b", res_idx_q.size(), err_at_done);
      run_layer(1'b0);
      n_checks++;
      if (err_post !== 1'b0) $display("FAIL to_err_clear: got %b expected 0", err_post);
      else n_pass++;
      n_checks++;
      if (layer_to || res_idx_q.size() != NN || err_at_done !== 1'b0) $display("FAIL to_rerun: got %0d results err %b expected %0d err 0", res_idx_q.size(), err_at_done, NN);
      else n_pass++;
      $display("timeout_rerun: %0d results, err %b", res_idx_q.size(), err_at_done);
   endtask

   task automatic test_reset_mid_layer();
      layer_in = {32{4'h1}};
      fill_rom({32'hFFFF_FFFF, 1'b1});
      clear_mon();
      exp_nin = layer_in;
      @(posedge clk);
      #2;
      in_vec = layer_in;
      start  = 1'b1;
      s_cyc  = cyc;
      @(posedge clk);
      #2;
      start = 1'b0;
      while (cyc < s_cyc + 38) begin
         @(posedge clk);
         #2;
      end
      reset = 1'b0;
      @(posedge clk);
      #3;
      n_checks++;
      if ({busy, done, err, res_valid, nbus.wmem_rd, nbus.n_start} !== 6'b0) $display("FAIL mid_reset_ctrl: got %b expected 000000", {busy, done, err, res_valid, nbus.wmem_rd, nbus.n_start});
      else n_pass++;
      n_checks++;
      if (nbus.n_in !== '0 || nbus.n_weight !== '0 || res_data !== '0 || res_idx !== '0 || res_bits !== '0) $display("FAIL mid_reset_data: got n_in %0h data %0h expected 0", nbus.n_in, res_data);
      else n_pass++;
      n_checks++;
      if (res_idx_q.size() != 7) $display("FAIL mid_reset_partial: got %0d results expected 7", res_idx_q.size());
      else n_pass++;
      @(posedge clk);
      #2;
      reset = 1'b1;
      repeat (6) @(posedge clk);
      #3;
      n_checks++;
      if (done_cnt != 0) $display("FAIL mid_reset_no_done: got %0d pulses expected 0", done_cnt);
      else n_pass++;
      run_layer(1'b0);
      n_checks++;
      if (layer_to || res_idx_q.size() != NN || res_idx_q[0] !== 4'd0 || res_idx_q[NN-1] !== 4'd15) $display("FAIL mid_reset_rerun: got %0d results expected %0d from idx 0", res_idx_q.size(), NN);
      else n_pass++;
      $display("reset_mid_layer: rerun produced %0d results", res_idx_q.size());
   endtask

   task automatic test_random();
      int bad;
      logic [SUM_W-1:0] exp_d;
      for (int l = 0; l < 100; l++) begin
         layer_in = {$urandom(), $urandom(), $urandom(), $urandom()};
         for (int i = 0; i < NN; i++) rom[i] = {32'($urandom()), 1'($urandom_range(0, 1))};
         run_layer(1'b0);
         bad = 0;
         n_checks++;
         if (layer_to || res_idx_q.size() != NN) begin
            $display("FAIL rand_count: layer %0d got %0d results expected %0d", l, res_idx_q.size(), NN);
         end else begin
            n_pass++;
            for (int i = 0; i < NN; i++) begin
               exp_d = calc(layer_in, rom[i][32:1], rom[i][0]);
               if (res_data_q[i] !== exp_d || res_idx_q[i] !== IDX_W'(i)) begin
                  if (bad == 0) $display("FAIL rand_data: layer %0d idx %0d got %0h expected %0h", l, i, res_data_q[i], exp_d);
                  bad++;
               end
            end
         end
         n_checks++;
         if (bits_at_done !== ref_bits()) $display("FAIL rand_bits: layer %0d got %0h expected %0h", l, bits_at_done, ref_bits());
         else n_pass++;
         n_checks++;
         if (nin_bad) $display("FAIL rand_n_in: layer %0d got n_in change while busy expected stable", l);
         else n_pass++;
         n_checks++;
         if (bad != 0) $display("FAIL rand_data_total: layer %0d got %0d bad results expected 0", l, bad);
         else n_pass++;
         $display("random layer %0d: bits %0h mismatches %0d", l, bits_at_done, bad);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_negative_row();
      test_start_held();
      test_timeout();
      test_reset_mid_layer();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
